// File: rtl/peri_readout_pkg.sv
// Shared constants, state encoding and row-index type for the crossbar readout path.
package peri_pkg;

    localparam int COL_NO      = 8;
    localparam int PAIR_ROW_NO = 4;
    localparam int ROW_NO      = 2 * PAIR_ROW_NO;
    localparam int ROW_W       = $clog2(ROW_NO);

    typedef logic [ROW_W-1:0] row_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SENSE,
        OUT,
        DONE
    } peri_rd_state_t;

endpackage

// File: rtl/peri_readout_if.sv
// Readout word stream: captured column word plus its physical row index, valid/ready handshake.
interface peri_readout_if #(
    parameter int COL_NO = peri_pkg::COL_NO,
    parameter int ROW_W  = peri_pkg::ROW_W
);

    logic [COL_NO-1:0] rd_data;
    logic [ROW_W-1:0]  rd_row;
    logic              rd_valid;
    logic              rd_ready;

    modport master (
        output rd_data,
        output rd_row,
        output rd_valid,
        input  rd_ready
    );

    modport slave (
        input  rd_data,
        input  rd_row,
        input  rd_valid,
        output rd_ready
    );

endinterface

// File: rtl/peri_readout_row_onehot.sv
// Physical row index to paired row0/row1 drive vectors; even rows on row0, odd rows on row1.
module peri_row_onehot #(
    parameter  int PAIR_ROW_NO = peri_pkg::PAIR_ROW_NO,
    localparam int ROW_W       = $clog2(2 * PAIR_ROW_NO)
) (
    input  logic [ROW_W-1:0]       idx,
    input  logic                   en,
    output logic [PAIR_ROW_NO-1:0] row0,
    output logic [PAIR_ROW_NO-1:0] row1
);

    always_comb begin
        row0 = '0;
        row1 = '0;
        for (int unsigned p = 0; p < PAIR_ROW_NO; p++) begin
            row0[p] = en && (idx == ROW_W'(2 * p));
            row1[p] = en && (idx == ROW_W'(2 * p + 1));
        end
    end

endmodule

// File: rtl/peri_readout.sv
// Row-by-row sense sequencer: drive row, settle, strobe sense amps, stream the captured word.
module peri_readout #(
    parameter int COL_NO      = peri_pkg::COL_NO,
    parameter int PAIR_ROW_NO = peri_pkg::PAIR_ROW_NO,
    parameter int SETTLE_CYC  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    output logic [PAIR_ROW_NO-1:0] row0,
    output logic [PAIR_ROW_NO-1:0] row1,
    output logic                   sa_en,
    input  logic [COL_NO-1:0]      sa_out,
    peri_readout_if.master         rd,
    output logic                   busy,
    output logic                   done
);

    import peri_pkg::*;

    localparam int               N_ROWS      = 2 * PAIR_ROW_NO;
    localparam int               RW          = $clog2(N_ROWS);
    localparam logic [RW-1:0]    LAST_ROW    = RW'(N_ROWS - 1);
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);

    peri_rd_state_t         state;
    logic [RW-1:0]          r;
    logic [3:0]             settle;
    logic [RW-1:0]          drive_idx;
    logic                   drive_en;
    logic [PAIR_ROW_NO-1:0] next_row0;
    logic [PAIR_ROW_NO-1:0] next_row1;

    // Row lines are registered, so decode the row about to be entered rather than the current one.
    always_comb begin
        drive_idx = '0;
        drive_en  = 1'b0;
        if (state == IDLE) begin
            drive_en = 1'b1;
        end else if (state == OUT && r != LAST_ROW) begin
            drive_idx = r + 1'b1;
            drive_en  = 1'b1;
        end
    end

    peri_row_onehot #(
        .PAIR_ROW_NO(PAIR_ROW_NO)
    ) u_onehot (
        .idx (drive_idx),
        .en  (drive_en),
        .row0(next_row0),
        .row1(next_row1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            r           <= '0;
            settle      <= '0;
            row0        <= '0;
            row1        <= '0;
            sa_en       <= 1'b0;
            rd.rd_data  <= '0;
            rd.rd_row   <= '0;
            rd.rd_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (abort && state != IDLE) begin
            state       <= IDLE;
            settle      <= '0;
            row0        <= '0;
            row1        <= '0;
            sa_en       <= 1'b0;
            rd.rd_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        r      <= '0;
                        settle <= '0;
                        row0   <= next_row0;
                        row1   <= next_row1;
                        busy   <= 1'b1;
                        state  <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle == SETTLE_LAST) begin
                        sa_en <= 1'b1;
                        state <= SENSE;
                    end else begin
                        settle <= settle + 1'b1;
                    end
                end
                SENSE: begin
                    rd.rd_data  <= sa_out;
                    rd.rd_row   <= r;
                    rd.rd_valid <= 1'b1;
                    sa_en       <= 1'b0;
                    row0        <= '0;
                    row1        <= '0;
                    state       <= OUT;
                end
                OUT: begin
                    if (rd.rd_ready) begin
                        rd.rd_valid <= 1'b0;
                        if (r == LAST_ROW) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            r      <= r + 1'b1;
                            settle <= '0;
                            row0   <= next_row0;
                            row1   <= next_row1;
                            state  <= DRIVE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_peri_readout.sv
// Directed bench for peri_readout: scoreboarded word stream, row pattern, latency, stall, abort, reset.
module tb_peri_readout;

    import peri_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] row0;
    logic [3:0] row1;
    logic       sa_en;
    logic [7:0] sa_out;
    logic       busy;
    logic       done;

    peri_readout_if rd_if ();

    peri_readout #(
        .COL_NO     (8),
        .PAIR_ROW_NO(4),
        .SETTLE_CYC (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .row0  (row0),
        .row1  (row1),
        .sa_en (sa_en),
        .sa_out(sa_out),
        .rd    (rd_if),
        .busy  (busy),
        .done  (done)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          sense_idx = 0;
    int          accepted = 0;
    int          special_row = -1;
    logic [7:0]  special_val = 8'h3C;
    logic [15:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_val(input int r);
        if (r == special_row) return special_val;
        return 8'(8'hA0 + r);
    endfunction

    // {row1,row0} pattern that must be driven while physical row r is sensed
    function automatic logic [7:0] model_rows(input int r);
        logic [7:0] v;
        v = '0;
        v[(r % 2) * 4 + r / 2] = 1'b1;
        return v;
    endfunction

    // Sense-amp model: returns the word of whichever row line is currently high
    always_comb begin
        sa_out = 8'hFF;
        for (int p = 0; p < 4; p++) begin
            if (row0[p]) sa_out = (special_row == 2 * p) ? special_val : 8'(8'hA0 + 2 * p);
            if (row1[p]) sa_out = (special_row == 2 * p + 1) ? special_val : 8'(8'hA1 + 2 * p);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Check the current cycle's outputs against the scoreboard, then advance one clock
    task automatic cycle();
        logic [15:0] e;
        chk("onehot", 32'($countones({row1, row0}) <= 1), 1);
        if (sa_en) begin
            chk("sense_rows", {row1, row0}, model_rows(sense_idx));
            exp_q.push_back({8'(sense_idx), exp_val(sense_idx)});
            sense_idx++;
        end
        if (rd_if.rd_valid) begin
            chk("rows_low_in_out", {row1, row0}, 0);
            chk("q_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                chk("rd_row", rd_if.rd_row, e[15:8]);
                chk("rd_data", rd_if.rd_data, e[7:0]);
                if (rd_if.rd_ready) begin
                    void'(exp_q.pop_front());
                    accepted++;
                end
            end
        end
        if (done) chk("busy_at_done", busy, 0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_scan(input string tag, input int stall_row, input int stall_len,
                            input int restart_at, input int exp_done);
        int s;
        int first;
        int done_at;
        int stalls;
        bit pulsed;
        first = -1; done_at = -1; stalls = 0; pulsed = 0;
        sense_idx = 0; accepted = 0; exp_q.delete();
        s = cyc;
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk({tag, "_busy_rise"}, busy, 1);
        for (int i = 0; i < 300 && done_at < 0; i++) begin
            if (rd_if.rd_valid && accepted == stall_row && stalls < stall_len) begin
                rd_if.rd_ready = 1'b0;
                stalls++;
            end else begin
                rd_if.rd_ready = 1'b1;
            end
            if (accepted == restart_at && !pulsed) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            cycle();
            start = 1'b0;
            if (rd_if.rd_valid && first < 0) first = cyc - s;
            if (done) done_at = cyc - s;
        end
        chk({tag, "_first_valid"}, first, 5);
        chk({tag, "_done_cycle"}, done_at, exp_done);
        chk({tag, "_words"}, accepted, 8);
        chk({tag, "_q_empty"}, exp_q.size(), 0);
        cycle();
        chk({tag, "_done_pulse_1cyc"}, done, 0);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        int  guard;
        bit  hit;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        rd_if.rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset values over an idle stretch
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("rst_rows", {row1, row0}, 0);
            chk("rst_sa_en", sa_en, 0);
            chk("rst_valid", rd_if.rd_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
        end
        chk("rst_data", rd_if.rd_data, 0);
        chk("rst_row", rd_if.rd_row, 0);

        // Uninterrupted scan, ready tied high
        run_scan("plain", -1, 0, -1, 41);

        // Backpressure on row 2 with a distinct word
        special_row = 2;
        run_scan("stall", 2, 6, -1, 47);
        special_row = -1;

        // Restart request mid-scan must be ignored
        run_scan("restart_ign", -1, 0, 3, 41);

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        cycle();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        cycle();
        chk("start_abort_rows", {row1, row0}, 0);

        // Abort while row 4 is driven
        sense_idx = 0; accepted = 0; exp_q.delete();
        rd_if.rd_ready = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        hit = 0;
        for (guard = 0; guard < 100 && !hit; guard++) begin
            cycle();
            if (accepted == 4 && row0[2]) hit = 1;
        end
        chk("abort_reach_row4", hit, 1);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_rows", {row1, row0}, 0);
        chk("abort_sa_en", sa_en, 0);
        chk("abort_valid", rd_if.rd_valid, 0);
        chk("abort_no_done", done, 0);
        chk("abort_data_kept", rd_if.rd_data, 8'hA3);
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("abort_stay_idle", {busy, done, sa_en, rd_if.rd_valid}, 0);
        end
        run_scan("after_abort", -1, 0, -1, 41);

        // Synchronous reset during SENSE of row 1
        sense_idx = 0; accepted = 0; exp_q.delete();
        start = 1'b1;
        cycle();
        start = 1'b0;
        hit = 0;
        for (guard = 0; guard < 100 && !hit; guard++) begin
            cycle();
            if (sa_en && accepted == 1) hit = 1;
        end
        chk("rst_reach_sense", hit, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_rows", {row1, row0}, 0);
        chk("midrst_sa_en", sa_en, 0);
        chk("midrst_valid", rd_if.rd_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_data", rd_if.rd_data, 0);
        chk("midrst_row", rd_if.rd_row, 0);
        exp_q.delete();
        cycle();
        run_scan("after_rst", -1, 0, -1, 41);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/peri_readout.md
Name: peri_readout

Overview:
- Read-side sequencer for the crossbar array peripheral; the return path of the row/column drive logic.
- On `start`, scans every physical row (2*PAIR_ROW_NO rows, organised as row0/row1 pairs), one row at a time.
- For each row: drives the row line one-hot, waits a settle time, strobes the sense amplifiers, and captures the COL_NO-bit column word.
- Presents each captured word on a valid/ready stream toward the host or accumulator logic.

Parameters:
- COL_NO, 8, number of columns = sense-amp word width
- PAIR_ROW_NO, 4, number of row pairs; physical rows = 2*PAIR_ROW_NO
- SETTLE_CYC, 3, cycles a row line is held before sensing; legal range 1..15

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a full-array scan; honoured only in IDLE
- abort  in  1  terminate the scan; return to IDLE next cycle
- row0  out  PAIR_ROW_NO  even-row drive lines, one-hot or zero
- row1  out  PAIR_ROW_NO  odd-row drive lines, one-hot or zero
- sa_en  out  1  sense-amp strobe, one cycle per row
- sa_out  in  COL_NO  sense-amp outputs, valid in the SENSE cycle
- rd_data  out  COL_NO  captured column word
- rd_row  out  $clog2(2*PAIR_ROW_NO)  physical row index of rd_data
- rd_valid  out  1  rd_data/rd_row valid
- rd_ready  in  1  downstream accepts the word
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- All outputs are registered. On reset: state=IDLE; row0, row1, sa_en, rd_data, rd_row, rd_valid, busy, done are all 0.
- Row mapping: row index r → pair p = r>>1. r[0]=0 drives row0[p]; r[0]=1 drives row1[p]. At most one bit across {row0,row1} is high at any time.
- States: IDLE, DRIVE, SENSE, OUT, DONE.
- IDLE:
  - start=1 → r=0, settle counter cleared, go to DRIVE.
  - busy rises the cycle after start is sampled.
- DRIVE:
  - Row line for r is high.
  - Settle counter increments each cycle; after SETTLE_CYC cycles in DRIVE, go to SENSE.
- SENSE (1 cycle):
  - Row line is still high; sa_en=1.
  - sa_out is captured into rd_data at the edge leaving SENSE, and rd_row<=r.
  - Go to OUT.
- OUT:
  - Row lines low; rd_valid=1.
  - rd_data and rd_row are held stable until the handshake.
  - On rd_valid&&rd_ready: if r==2*PAIR_ROW_NO-1, go to DONE; else r<=r+1 and go to DRIVE.
  - rd_valid drops the cycle after acceptance.
- DONE (1 cycle): done=1, busy=0 in the same cycle, then IDLE.
- Latency:
  - Start to first rd_valid = SETTLE_CYC+2 cycles.
  - Per row with rd_ready tied high = SETTLE_CYC+2 cycles.
  - Full scan = 2*PAIR_ROW_NO*(SETTLE_CYC+2)+1 cycles, start to done.
- Backpressure: rd_ready low stalls in OUT indefinitely. No row is driven while stalled.
- start while busy is ignored, with no restart.
- start and abort in the same IDLE cycle: abort wins; stay in IDLE.
- abort in any non-IDLE state:
  - Next cycle: IDLE with all row lines, sa_en, rd_valid and busy at 0; done is not pulsed.
  - rd_data keeps its last value.
- rst mid-scan: identical to the reset values above, taking effect in the cycle after assertion.
- Row counter wrap: never increments past 2*PAIR_ROW_NO-1; reset to 0 on each start.

Decomposition:
- Shared package peri_pkg holds:
  - localparams COL_NO=8, PAIR_ROW_NO=4, ROW_NO=2*PAIR_ROW_NO
  - typedef enum logic [2:0] peri_rd_state_t {IDLE, DRIVE, SENSE, OUT, DONE}
  - typedef for the row index type
- One sub-module, peri_row_onehot:
  - Combinational: row index plus enable → row0/row1 one-hot vectors.
  - Registered in peri_readout.

Test Plan:
- Reset, then idle 10 cycles → all outputs 0; row0=row1=0, rd_valid=0.
- SETTLE_CYC=3, rd_ready=1, sa_out=8'hA0+r during each SENSE:
  - 8 words in order: rd_row=0..7, rd_data=A0..A7.
  - First rd_valid 5 cycles after start; done pulses at cycle 41.
  - Row pattern: row0=0001 for r=0, row1=0001 for r=1, …, row1=1000 for r=7.
- rd_ready low for 6 cycles at r=2 (sa_out=8'h3C) → rd_valid and rd_data=3C held; row lines 0 while stalled; scan resumes at r=3 after ready.
- abort asserted during DRIVE of r=4 → next cycle IDLE; busy=0, row lines 0, no done; a following start restarts at r=0.
- start pulsed again mid-scan → ignored; word sequence and timing identical to the uninterrupted case.
- rst asserted during SENSE → next cycle all outputs 0, state IDLE; subsequent start gives a full 8-word scan.
